temp_prog_multi: RTL and testbench

Multi-channel programmable interval timer; successor of the fixed 15-cycle timer used by the controller FSMs. Each of CHANNELS independent channels counts a run-time period (1 to 2^WIDTH-1 counting ticks), runs in one-shot or periodic mode, and emits a one-cycle expire pulse. Counting advances only on a shared tick enable, so a single prescaled enable (e.g. 1 Hz) drives second-based delays without extra clock domains.

---
 rtl/temp_prog_multi.sv | 88 ++++++++
 tb/tb_temp_prog_multi.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/temp_prog_multi.sv
`default_nettype none
// ============================================================================
//  Module   : temp_prog_multi
//  Purpose  : Multi-channel programmable interval timer. Each channel loads a
//             run-time period, counts down on a shared tick enable, and emits
//             a one-cycle expire pulse in one-shot or auto-reload mode.
//  Revision : 1.0  initial release
// ============================================================================
module temp_prog_multi #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      tick_en,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       stop,
    input  logic [CHANNELS-1:0]       periodic,
    input  logic [WIDTH-1:0]          period,
    output logic [CHANNELS-1:0]       expire,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS*WIDTH-1:0] remaining
);

    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_zero = '0;

    // A zero period is not a legal load; such a start is ignored entirely.
    logic w_period_valid;
    assign w_period_valid = (period != c_zero);

    // Reload value shared by every channel that starts on this edge.
    logic [WIDTH-1:0] w_load_count;
    assign w_load_count = period - c_one;

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic [WIDTH-1:0] r_count;
            logic [WIDTH-1:0] r_period;
            logic             r_mode;
            logic             r_busy;
            logic             r_expire;

            // Per-channel countdown: stop > valid start > tick-driven count.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_count  <= c_zero;
                    r_period <= c_zero;
                    r_mode   <= 1'b0;
                    r_busy   <= 1'b0;
                    r_expire <= 1'b0;
                end else if (stop[i]) begin
                    r_count  <= c_zero;
                    r_busy   <= 1'b0;
                    r_expire <= 1'b0;
                end else if (start[i] && w_period_valid) begin
                    // The load edge itself never counts as a tick.
                    r_period <= period;
                    r_mode   <= periodic[i];
                    r_count  <= w_load_count;
                    r_busy   <= 1'b1;
                    r_expire <= 1'b0;
                end else if (r_busy && tick_en) begin
                    if (r_count == c_zero) begin
                        r_expire <= 1'b1;
                        if (r_mode) begin
                            // Reload immediately so pulses repeat with no gap.
                            r_count <= r_period - c_one;
                        end else begin
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_count  <= r_count - c_one;
                        r_expire <= 1'b0;
                    end
                end else begin
                    r_expire <= 1'b0;
                end
            end

            assign expire[i]                   = r_expire;
            assign busy[i]                     = r_busy;
            assign remaining[i*WIDTH +: WIDTH] = r_count;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_temp_prog_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_temp_prog_multi
//  Purpose  : Self-checking bench for temp_prog_multi. An elapsed-tick model
//             is compared every cycle; directed vectors add literal checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_temp_prog_multi;

    localparam int WIDTH    = 4;
    localparam int CHANNELS = 2;

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic                      tick_en;
    logic [CHANNELS-1:0]       start;
    logic [CHANNELS-1:0]       stop;
    logic [CHANNELS-1:0]       periodic;
    logic [WIDTH-1:0]          period;
    logic [CHANNELS-1:0]       expire;
    logic [CHANNELS-1:0]       busy;
    logic [CHANNELS*WIDTH-1:0] remaining;

    int vectors     = 0;
    int miscompares = 0;

    temp_prog_multi #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .tick_en   (tick_en),
        .start     (start),
        .stop      (stop),
        .periodic  (periodic),
        .period    (period),
        .expire    (expire),
        .busy      (busy),
        .remaining (remaining)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Model: each channel tracks how many qualifying ticks have elapsed
    // since its load; it fires when elapsed reaches the loaded period.
    // ------------------------------------------------------------------
    bit m_armed   [CHANNELS];
    bit m_mode    [CHANNELS];
    int m_per     [CHANNELS];
    int m_elapsed [CHANNELS];
    bit m_pulse   [CHANNELS];

    // Model update on each edge, then per-cycle comparison 1 ns later.
    always @(posedge clk) begin
        logic [CHANNELS-1:0]       exp_expire;
        logic [CHANNELS-1:0]       exp_busy;
        logic [CHANNELS*WIDTH-1:0] exp_rem;
        for (int c = 0; c < CHANNELS; c++) begin
            m_pulse[c] = 1'b0;
            if (!reset_n) begin
                m_armed[c]   = 1'b0;
                m_mode[c]    = 1'b0;
                m_per[c]     = 0;
                m_elapsed[c] = 0;
            end else if (stop[c]) begin
                m_armed[c] = 1'b0;
            end else if (start[c] && period != 0) begin
                m_armed[c]   = 1'b1;
                m_mode[c]    = periodic[c];
                m_per[c]     = int'(period);
                m_elapsed[c] = 0;
            end else if (m_armed[c] && tick_en) begin
                m_elapsed[c] = m_elapsed[c] + 1;
                if (m_elapsed[c] == m_per[c]) begin
                    m_pulse[c]   = 1'b1;
                    m_elapsed[c] = 0;
                    if (!m_mode[c]) m_armed[c] = 1'b0;
                end
            end
        end
        for (int c = 0; c < CHANNELS; c++) begin
            exp_expire[c] = m_pulse[c];
            exp_busy[c]   = m_armed[c];
            exp_rem[c*WIDTH +: WIDTH] = m_armed[c] ? WIDTH'(m_per[c] - 1 - m_elapsed[c]) : '0;
        end
        #1;
        vectors++;
        if (expire !== exp_expire || busy !== exp_busy || remaining !== exp_rem) begin
            miscompares++;
            $display("FAIL model t=%0t expire=%b/%b busy=%b/%b remaining=%h/%h (actual/required)",
                     $time, expire, exp_expire, busy, exp_busy, remaining, exp_rem);
        end
    end

    // Literal check against a hand-computed value.
    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic nedge();
        @(negedge clk);
    endtask

    function automatic int rem(input int c);
        return int'(remaining[c*WIDTH +: WIDTH]);
    endfunction

    // Watchdog: the directed sequence is bounded, this only guards a hang.
    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n  = 1'b0;
        tick_en  = 1'b0;
        start    = '0;
        stop     = '0;
        periodic = '0;
        period   = '0;

        // Reset values and idle tick toggling.
        repeat (3) nedge();
        check("reset_expire", int'(expire), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_remaining", int'(remaining), 0);
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick_en = k[0];
            nedge();
            check("idle_no_pulse", int'(expire), 0);
        end

        // Periodic, P=15: pulses after edges 15, 30, 45.
        tick_en = 1'b1; start = 2'b01; period = 4'd15; periodic = 2'b01;
        nedge();
        start = '0; period = '0;
        for (int k = 1; k <= 46; k++) begin
            nedge();
            check("periodic_expire0", int'(expire[0]), (k % 15 == 0) ? 1 : 0);
            check("periodic_busy0", int'(busy[0]), 1);
        end

        // One-shot P=3 on ch1, tick every 4th clock; the start edge has tick high.
        start = 2'b10; period = 4'd3; periodic = 2'b00; tick_en = 1'b1;
        nedge();
        start = '0;
        for (int k = 1; k <= 50; k++) begin
            tick_en = (k % 4 == 0);
            nedge();
            check("oneshot_expire1", int'(expire[1]), (k == 12) ? 1 : 0);
            if (k >= 12) begin
                check("oneshot_busy1", int'(busy[1]), 0);
                check("oneshot_rem1", rem(1), 0);
            end
        end

        // Stop ch0 periodic run.
        tick_en = 1'b1; stop = 2'b01;
        nedge();
        stop = '0;
        check("stop_busy0", int'(busy[0]), 0);

        // Stop and start together on idle ch1.
        start = 2'b10; stop = 2'b10; period = 4'd9;
        nedge();
        start = '0; stop = '0;
        check("stopstart_busy1", int'(busy[1]), 0);
        check("stopstart_rem1", rem(1), 0);

        // Stop on the completing edge suppresses the pulse.
        start = 2'b01; period = 4'd2; periodic = 2'b00;
        nedge();
        start = '0;
        nedge();
        check("pre_stop_rem0", rem(0), 0);
        stop = 2'b01;
        nedge();
        stop = '0;
        check("stop_at_zero_expire0", int'(expire[0]), 0);
        check("stop_at_zero_busy0", int'(busy[0]), 0);
        nedge();
        check("stop_at_zero_late_expire0", int'(expire[0]), 0);

        // Zero-period start on a running channel is ignored.
        start = 2'b10; period = 4'd5;
        nedge();
        start = '0;
        nedge();
        start = 2'b10; period = 4'd0;
        nedge();
        start = '0;
        check("zero_period_rem1", rem(1), 2);
        check("zero_period_busy1", int'(busy[1]), 1);
        for (int k = 3; k <= 6; k++) begin
            nedge();
            check("zero_period_expire1", int'(expire[1]), (k == 5) ? 1 : 0);
        end

        // Restart ch0 at remaining 4, then start ch1 one edge later.
        start = 2'b01; period = 4'd10;
        nedge();
        start = '0;
        repeat (5) nedge();
        check("restart_pre_rem0", rem(0), 4);
        start = 2'b01; period = 4'd5;
        nedge();
        check("restart_rem0", rem(0), 4);
        start = 2'b10; period = 4'd7;
        nedge();
        start = '0;
        check("indep_rem1", rem(1), 6);
        for (int k = 8; k <= 15; k++) begin
            nedge();
            check("restart_expire0", int'(expire[0]), (k == 11) ? 1 : 0);
            check("indep_expire1", int'(expire[1]), (k == 14) ? 1 : 0);
        end

        // Asynchronous reset while both channels are busy.
        start = 2'b11; period = 4'd6; periodic = 2'b11;
        nedge();
        start = '0;
        repeat (3) nedge();
        check("pre_reset_busy", int'(busy), 3);
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("async_busy", int'(busy), 0);
        check("async_expire", int'(expire), 0);
        check("async_remaining", int'(remaining), 0);
        nedge();
        nedge();
        reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            nedge();
            check("post_reset_expire", int'(expire), 0);
            check("post_reset_busy", int'(busy), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
